// File: rtl/clock_time_ctrl_if.sv
// clock_time_ctrl_if: bundle of control pulses and displayed time for the
// 24-hour BCD clock.
//   tick, mode, inc, dec      : single-cycle control pulses into the clock
//   hr/min/sec tens/ones      : registered BCD digits out of the clock
//   state                     : 00 RUN, 01 SET_HR, 10 SET_MIN, 11 SET_SEC
//   day_pulse                 : one-cycle pulse on 23:59:59 -> 00:00:00
// slave  = the clock block, master = whoever drives the pulses.
interface clock_time_ctrl_if;
    logic       tick;
    logic       mode;
    logic       inc;
    logic       dec;
    logic [3:0] hr_tens;
    logic [3:0] hr_ones;
    logic [3:0] min_tens;
    logic [3:0] min_ones;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic [1:0] state;
    logic       day_pulse;

    modport slave (
        input  tick, mode, inc, dec,
        output hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
               state, day_pulse
    );

    modport master (
        output tick, mode, inc, dec,
        input  hr_tens, hr_ones, min_tens, min_ones, sec_tens, sec_ones,
               state, day_pulse
    );
endinterface

// File: rtl/clock_time_ctrl.sv
// clock_time_ctrl: 24-hour HH:MM:SS BCD time-of-day counter with a
// mode-driven set FSM (RUN -> SET_HR -> SET_MIN -> SET_SEC -> RUN).
//   clk   : system clock, rising edge
//   reset : asynchronous, active-high; forces 00:00:00, RUN, day_pulse=0
//   bus   : clock_time_ctrl_if.slave (pulses in, registered digits out)
// Each field is held as an 8-bit BCD pair {tens, ones}.
module clock_time_ctrl (
    input  logic                  clk,
    input  logic                  reset,
    clock_time_ctrl_if.slave      bus
);
    localparam logic [1:0] ST_RUN     = 2'b00;
    localparam logic [1:0] ST_SET_HR  = 2'b01;
    localparam logic [1:0] ST_SET_MIN = 2'b10;
    localparam logic [1:0] ST_SET_SEC = 2'b11;

    logic [7:0] hr_q,  hr_d;
    logic [7:0] min_q, min_d;
    logic [7:0] sec_q, sec_d;
    logic [1:0] state_q, state_d;
    logic       day_q, day_d;

    // Increment a BCD pair, wrapping from lim back to 00.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        if (v == lim)          return 8'h00;
        if (v[3:0] == 4'd9)    return {v[7:4] + 4'd1, 4'd0};
        return {v[7:4], v[3:0] + 4'd1};
    endfunction

    // Decrement a BCD pair, wrapping from 00 up to lim.
    function automatic logic [7:0] bcd_dec(input logic [7:0] v, input logic [7:0] lim);
        if (v == 8'h00)        return lim;
        if (v[3:0] == 4'd0)    return {v[7:4] - 4'd1, 4'd9};
        return {v[7:4], v[3:0] - 4'd1};
    endfunction

    always_comb begin
        hr_d    = hr_q;
        min_d   = min_q;
        sec_d   = sec_q;
        state_d = state_q;
        day_d   = 1'b0;
        if (bus.mode) begin
            // mode wins over everything else in the same cycle
            state_d = state_q + 2'd1;
        end else if (state_q == ST_RUN) begin
            if (bus.tick) begin
                // full carry chain resolves in one edge
                sec_d = bcd_inc(sec_q, 8'h59);
                if (sec_q == 8'h59) begin
                    min_d = bcd_inc(min_q, 8'h59);
                    if (min_q == 8'h59) begin
                        hr_d = bcd_inc(hr_q, 8'h23);
                        if (hr_q == 8'h23) day_d = 1'b1;
                    end
                end
            end
        end else if (bus.inc ^ bus.dec) begin
            // set modes: selected field only, no carry/borrow; inc+dec cancels
            case (state_q)
                ST_SET_HR:  hr_d  = bus.inc ? bcd_inc(hr_q,  8'h23) : bcd_dec(hr_q,  8'h23);
                ST_SET_MIN: min_d = bus.inc ? bcd_inc(min_q, 8'h59) : bcd_dec(min_q, 8'h59);
                ST_SET_SEC: sec_d = bus.inc ? bcd_inc(sec_q, 8'h59) : bcd_dec(sec_q, 8'h59);
                default:    hr_d  = hr_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hr_q    <= 8'h00;
            min_q   <= 8'h00;
            sec_q   <= 8'h00;
            state_q <= ST_RUN;
            day_q   <= 1'b0;
        end else begin
            hr_q    <= hr_d;
            min_q   <= min_d;
            sec_q   <= sec_d;
            state_q <= state_d;
            day_q   <= day_d;
        end
    end

    assign bus.hr_tens   = hr_q[7:4];
    assign bus.hr_ones   = hr_q[3:0];
    assign bus.min_tens  = min_q[7:4];
    assign bus.min_ones  = min_q[3:0];
    assign bus.sec_tens  = sec_q[7:4];
    assign bus.sec_ones  = sec_q[3:0];
    assign bus.state     = state_q;
    assign bus.day_pulse = day_q;
endmodule

// File: tb/tb_clock_time_ctrl.sv
// Testbench for clock_time_ctrl. Stimulus is pushed into a scoreboard queue
// as expected responses from a seconds-of-day reference model; a monitor
// compares one entry after every rising edge. Directed scenarios also check
// literal expected times.
module tb_clock_time_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    clock_time_ctrl_if bus();

    clock_time_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct packed {
        logic [23:0] dig;
        logic [1:0]  st;
        logic        dp;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   failures = 0;

    // reference model: time as seconds since midnight, state as 0..3
    int m_t  = 0;
    int m_st = 0;
    bit m_dp = 0;

    function automatic exp_t mk_exp(int t, int st, bit dp);
        exp_t e;
        int h, mi, s;
        h  = t / 3600;
        mi = (t / 60) % 60;
        s  = t % 60;
        e.dig = {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10), 4'(s / 10), 4'(s % 10)};
        e.st  = 2'(st);
        e.dp  = dp;
        return e;
    endfunction

    task automatic check_out(string name, exp_t e);
        exp_t a;
        a.dig = {bus.hr_tens, bus.hr_ones, bus.min_tens, bus.min_ones, bus.sec_tens, bus.sec_ones};
        a.st  = bus.state;
        a.dp  = bus.day_pulse;
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got time=%h state=%b day=%b, want time=%h state=%b day=%b",
                     name, a.dig, a.st, a.dp, e.dig, e.st, e.dp);
        end
    endtask

    task automatic expect_now(string name, int h, int mi, int s, int st, bit dp);
        check_out(name, mk_exp(h * 3600 + mi * 60 + s, st, dp));
    endtask

    // model update for one clock edge with the given inputs
    task automatic model_step(bit tk, bit md, bit in_, bit de, bit rs);
        int h, mi, s;
        m_dp = 0;
        if (rs) begin
            m_t = 0; m_st = 0;
        end else if (md) begin
            m_st = (m_st + 1) % 4;
        end else if (m_st == 0) begin
            if (tk) begin
                m_t = (m_t + 1) % 86400;
                if (m_t == 0) m_dp = 1;
            end
        end else if (in_ != de) begin
            h  = m_t / 3600;
            mi = (m_t / 60) % 60;
            s  = m_t % 60;
            if (m_st == 1) h  = in_ ? (h + 1) % 24  : (h + 23) % 24;
            if (m_st == 2) mi = in_ ? (mi + 1) % 60 : (mi + 59) % 60;
            if (m_st == 3) s  = in_ ? (s + 1) % 60  : (s + 59) % 60;
            m_t = h * 3600 + mi * 60 + s;
        end
    endtask

    // drive one cycle of inputs at negedge, return just after the posedge
    task automatic step(bit tk, bit md, bit in_, bit de, bit rs = 1'b0);
        @(negedge clk);
        reset    = rs;
        bus.tick = tk;
        bus.mode = md;
        bus.inc  = in_;
        bus.dec  = de;
        model_step(tk, md, in_, de, rs);
        q.push_back(mk_exp(m_t, m_st, m_dp));
        @(posedge clk);
        #1;
        bus.tick = 0; bus.mode = 0; bus.inc = 0; bus.dec = 0;
        #1;
    endtask

    task automatic set_time(int h, int mi, int s);
        step(0, 1, 0, 0);
        while (m_t / 3600 != h) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        while ((m_t / 60) % 60 != mi) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        while (m_t % 60 != s) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
    endtask

    // scoreboard monitor
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) check_out("scoreboard", q.pop_front());
        end
    end

    initial begin
        bus.tick = 0; bus.mode = 0; bus.inc = 0; bus.dec = 0;
        #3;
        expect_now("reset_state", 0, 0, 0, 0, 0);
        step(1, 1, 1, 0, 1);
        expect_now("reset_held", 0, 0, 0, 0, 0);

        // 61 ticks from reset
        for (int i = 0; i < 61; i++) step(1, 0, 0, 0);
        expect_now("61_ticks", 0, 1, 1, 0, 0);

        // inc/dec ignored in RUN
        step(0, 0, 1, 0);
        step(0, 0, 0, 1);
        expect_now("run_ignores_incdec", 0, 1, 1, 0, 0);

        // day rollover
        set_time(23, 59, 59);
        expect_now("set_235959", 23, 59, 59, 0, 0);
        step(1, 0, 0, 0);
        expect_now("rollover", 0, 0, 0, 0, 1);
        step(0, 0, 0, 0);
        expect_now("day_pulse_one_cycle", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        expect_now("after_rollover", 0, 0, 1, 0, 0);

        // set-mode wrap boundaries
        step(0, 0, 0, 0, 1);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        expect_now("hr_dec_wrap", 23, 0, 0, 1, 0);
        step(0, 0, 1, 0);
        expect_now("hr_inc_wrap", 0, 0, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 1, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        expect_now("min_dec_wrap", 5, 59, 0, 2, 0);
        step(0, 0, 1, 0);
        expect_now("min_inc_wrap", 5, 0, 0, 2, 0);
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);
        expect_now("sec_dec_wrap", 5, 0, 59, 3, 0);
        step(0, 1, 0, 0);

        // frozen time in SET_MIN, inc+dec cancel
        set_time(12, 34, 56);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        for (int i = 0; i < 10; i++) step(1, 0, 0, 0);
        step(0, 0, 1, 1);
        expect_now("set_min_frozen", 12, 34, 56, 2, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);

        // mode with tick; state cycle
        set_time(9, 59, 59);
        step(1, 1, 0, 0);
        expect_now("mode_tick", 9, 59, 59, 1, 0);
        step(1, 1, 1, 0);
        expect_now("mode2", 9, 59, 59, 2, 0);
        step(0, 1, 0, 1);
        expect_now("mode3", 9, 59, 59, 3, 0);
        step(0, 1, 0, 0);
        expect_now("mode4", 9, 59, 59, 0, 0);
        step(1, 0, 0, 0);
        expect_now("full_carry", 10, 0, 0, 0, 0);

        // asynchronous reset between edges in SET_SEC
        set_time(15, 20, 30);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        expect_now("pre_async", 15, 20, 30, 3, 0);
        #2;
        reset = 1;
        #1;
        expect_now("async_reset", 0, 0, 0, 0, 0);
        m_t = 0; m_st = 0; m_dp = 0;
        step(1, 1, 1, 0, 1);
        step(1, 0, 0, 0);
        expect_now("post_reset_tick", 0, 0, 1, 0, 0);

        // randomized phase
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(1) == 1, $urandom_range(7) == 0,
                 $urandom_range(3) == 0, $urandom_range(3) == 0,
                 $urandom_range(199) == 0);
        end

        repeat (2) @(posedge clk);
        #2;
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL queue_drain: got %0d pending, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // absolute time bound
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish, want completion");
        $fatal(1, "timeout");
    end
endmodule
